instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch_if.sv | 30 +++
 rtl/instruction_fetch.sv | 97 +++++++++
 tb/tb_instruction_fetch.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle.
// Groups the control inputs (start, stall, redirect requests), the instruction ROM
// port and the issued-instruction outputs of instruction_fetch.
//   master : the fetch unit (drives rom_address, instr_*, running, halted)
//   slave  : the surrounding environment (drives start, stall, redirects, ROM data)
interface instruction_fetch_if;
  logic       start;
  logic       stall;
  logic       jump_en;
  logic [7:0] jump_target;
  logic       branch_en;
  logic [7:0] branch_offset;
  logic [7:0] rom_address;
  logic [8:0] rom_instruction;
  logic [8:0] instr_out;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       running;
  logic       halted;

  modport master (
    input  start, stall, jump_en, jump_target, branch_en, branch_offset, rom_instruction,
    output rom_address, instr_out, instr_pc, instr_valid, running, halted
  );

  modport slave (
    output start, stall, jump_en, jump_target, branch_en, branch_offset, rom_instruction,
    input  rom_address, instr_out, instr_pc, instr_valid, running, halted
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit.
// Sequences a PC through a combinational instruction ROM, issuing one registered
// instruction per cycle in FETCH. Supports stall (hold), absolute jump and PC-relative
// branch redirects (one-cycle bubble) and stops in HALTED after issuing HALT_CODE.
// Ports:
//   clk   : sole clock, rising edge
//   reset : synchronous, active-high
//   bus   : instruction_fetch_if.master (control inputs, ROM port, issued instruction)
module instruction_fetch #(
  parameter logic [7:0] START_ADDR = 8'd0,
  parameter logic [8:0] HALT_CODE  = 9'b0111_00_010
) (
  input logic                  clk,
  input logic                  reset,
  instruction_fetch_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StHalted} state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [8:0] instr_q, instr_d;
  logic [7:0] ipc_q, ipc_d;
  logic       valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      pc_q    <= START_ADDR;
      instr_q <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (bus.start) begin
          pc_d    = START_ADDR;
          state_d = StFetch;
        end
      end
      StFetch: begin
        // Redirects come from the instruction currently issued, so they only count
        // while that instruction is live; they override stall and squash the issue.
        if (valid_q && bus.jump_en) begin
          pc_d    = bus.jump_target;
          valid_d = 1'b0;
        end else if (valid_q && bus.branch_en) begin
          pc_d    = ipc_q + bus.branch_offset;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          instr_d = bus.rom_instruction;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          if (bus.rom_instruction == HALT_CODE) begin
            state_d = StHalted;
          end else begin
            pc_d = pc_q + 8'd1;
          end
        end
      end
      StHalted: begin
        if (bus.start) begin
          pc_d    = START_ADDR;
          valid_d = 1'b0;
          state_d = StFetch;
        end else if (!bus.stall) begin
          // The halt stays visible until downstream accepts it.
          valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.rom_address = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.instr_valid = valid_q;
  assign bus.running     = (state_q == StFetch);
  assign bus.halted      = (state_q == StHalted);

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [8:0] Halt = 9'b0111_00_010;

  typedef struct {
    logic       start;
    logic       stall;
    logic       je;
    logic [7:0] jt;
    logic       be;
    logic [7:0] bo;
    logic       e_valid;
    logic [7:0] e_ipc;
    logic [7:0] e_addr;
    logic       e_run;
    logic       e_halt;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [8:0] rom [256];
  vec_t vecs [$];
  int n_checks = 0;
  int n_fail = 0;

  instruction_fetch_if ifc ();

  instruction_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  assign ifc.rom_instruction = rom[ifc.rom_address];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic st, input logic sl, input logic je,
                              input logic [7:0] jt, input logic be, input logic [7:0] bo,
                              input logic ev, input logic [7:0] eipc, input logic [7:0] ea,
                              input logic er, input logic eh);
    vec_t v;
    v.start = st; v.stall = sl; v.je = je; v.jt = jt; v.be = be; v.bo = bo;
    v.e_valid = ev; v.e_ipc = eipc; v.e_addr = ea; v.e_run = er; v.e_halt = eh;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic st, input logic sl, input logic je, input logic [7:0] jt,
                       input logic be, input logic [7:0] bo);
    ifc.start = st; ifc.stall = sl; ifc.jump_en = je; ifc.jump_target = jt;
    ifc.branch_en = be; ifc.branch_offset = bo;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(ifc.instr_valid), 32'd0);
    check({tag, "_out"}, 32'(ifc.instr_out), 32'd0);
    check({tag, "_ipc"}, 32'(ifc.instr_pc), 32'd0);
    check({tag, "_addr"}, 32'(ifc.rom_address), 32'd0);
    check({tag, "_run"}, 32'(ifc.running), 32'd0);
    check({tag, "_halt"}, 32'(ifc.halted), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {1'b1, 8'(i)};
    rom[4] = Halt;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    //   st sl je jt     be bo     valid ipc    addr   run halt
    add(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0);  // start
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 8'h01, 1, 0);
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h01, 8'h02, 1, 0);
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h02, 8'h03, 1, 0);
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h03, 8'h04, 1, 0);
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h04, 8'h04, 0, 1);  // halt issued, PC held
    add(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h04, 8'h04, 0, 1);  // valid clears
    add(0, 0, 1, 8'h20, 0, 8'h00, 0, 8'h04, 8'h04, 0, 1);  // jump ignored in HALTED
    add(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h04, 8'h00, 1, 0);  // restart
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 8'h01, 1, 0);
    add(0, 0, 1, 8'h05, 0, 8'h00, 0, 8'h00, 8'h05, 1, 0);  // skip past halt word
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h05, 8'h06, 1, 0);
    add(0, 0, 1, 8'h20, 0, 8'h00, 0, 8'h05, 8'h20, 1, 0);  // jump at pc 5
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h20, 8'h21, 1, 0);
    add(0, 0, 1, 8'h0A, 0, 8'h00, 0, 8'h20, 8'h0A, 1, 0);
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h0A, 8'h0B, 1, 0);
    add(0, 0, 0, 8'h00, 1, 8'hFE, 0, 8'h0A, 8'h08, 1, 0);  // branch -2
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h08, 8'h09, 1, 0);
    add(0, 0, 1, 8'h0A, 0, 8'h00, 0, 8'h08, 8'h0A, 1, 0);
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h0A, 8'h0B, 1, 0);
    add(0, 0, 0, 8'h00, 1, 8'h02, 0, 8'h0A, 8'h0C, 1, 0);  // branch +2
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h0C, 8'h0D, 1, 0);
    add(0, 0, 1, 8'h30, 1, 8'h02, 0, 8'h0C, 8'h30, 1, 0);  // jump beats branch
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h30, 8'h31, 1, 0);
    add(0, 0, 1, 8'h07, 0, 8'h00, 0, 8'h30, 8'h07, 1, 0);
    add(0, 0, 1, 8'h50, 0, 8'h00, 1, 8'h07, 8'h08, 1, 0);  // jump ignored while bubble
    add(0, 1, 0, 8'h00, 0, 8'h00, 1, 8'h07, 8'h08, 1, 0);  // stall x3 at pc 7
    add(0, 1, 0, 8'h00, 0, 8'h00, 1, 8'h07, 8'h08, 1, 0);
    add(0, 1, 0, 8'h00, 0, 8'h00, 1, 8'h07, 8'h08, 1, 0);
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h08, 8'h09, 1, 0);
    add(0, 1, 1, 8'hFF, 0, 8'h00, 0, 8'h08, 8'hFF, 1, 0);  // redirect beats stall
    add(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h08, 8'hFF, 1, 0);
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'hFF, 8'h00, 1, 0);  // PC wraps
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 8'h01, 1, 0);
    add(0, 0, 1, 8'hFA, 0, 8'h00, 0, 8'h00, 8'hFA, 1, 0);
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'hFA, 8'hFB, 1, 0);
    add(0, 0, 0, 8'h00, 1, 8'h10, 0, 8'hFA, 8'h0A, 1, 0);  // branch wraps
    add(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h0A, 8'h0B, 1, 0);
    add(1, 0, 0, 8'h00, 0, 8'h00, 1, 8'h0B, 8'h0C, 1, 0);  // start ignored in FETCH

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stall, vecs[i].je, vecs[i].jt, vecs[i].be, vecs[i].bo);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), 32'(ifc.instr_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_ipc", i), 32'(ifc.instr_pc), 32'(vecs[i].e_ipc));
      check($sformatf("v%0d_addr", i), 32'(ifc.rom_address), 32'(vecs[i].e_addr));
      check($sformatf("v%0d_run", i), 32'(ifc.running), 32'(vecs[i].e_run));
      check($sformatf("v%0d_halt", i), 32'(ifc.halted), 32'(vecs[i].e_halt));
      if (vecs[i].e_valid)
        check($sformatf("v%0d_out", i), 32'(ifc.instr_out), 32'(rom[vecs[i].e_ipc]));
    end

    // Reset during a stall with a pending jump, then restart.
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    check("stall_hold_ipc", 32'(ifc.instr_pc), 32'h0B);
    drive(1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("rst_stall");
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    check("restart_run", 32'(ifc.running), 32'd1);
    check("restart_addr", 32'(ifc.rom_address), 32'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    check("restart_valid", 32'(ifc.instr_valid), 32'd1);
    check("restart_ipc", 32'(ifc.instr_pc), 32'h00);
    check("restart_out", 32'(ifc.instr_out), 32'(rom[0]));

    // Run into the halt word, then reset from HALTED.
    repeat (4) @(posedge clk);
    #1;
    check("halt2_halt", 32'(ifc.halted), 32'd1);
    check("halt2_out", 32'(ifc.instr_out), 32'(Halt));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("rst_halt");
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
